// File: rtl/fixed_mult_pipe_if.sv
// Stream bundle for the pipelined fixed-point multiplier.
// The master side is the environment: it drives operands upstream and out_ready downstream.
// The slave side is the multiplier itself.
interface fixed_mult_pipe_if #(
    parameter int WIDTH = 22
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] result;
    logic                    overflow;
    logic                    busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, busy
    );
endinterface

// File: rtl/fixed_mult_pipe.sv
// Pipelined signed fixed-point multiplier (Q INTEGRAL.FRACTIONAL).
//
// Pipeline:
//   stage 0          operand registers
//   stage 1          full-precision product; with STAGES=2 this is also the final stage
//   stages 1..S-2    plain delay registers carrying the product
//   stage S-1        rounding, arithmetic shift and saturation/wrap into result
//
// All stages share one stall signal. The pipe advances whenever the output
// register is empty or is being drained, so a bubble is never squeezed out.
// Data registers load only when the entry entering them is valid. This keeps
// result steady across bubbles. FRACTIONAL must be at least 1.
module fixed_mult_pipe #(
    parameter int INTEGRAL   = 11,
    parameter int FRACTIONAL = 11,
    parameter int STAGES     = 3,
    parameter int ROUND      = 0,
    parameter int SATURATE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    fixed_mult_pipe_if.slave io_bus
);
    localparam int WIDTH = INTEGRAL + FRACTIONAL;
    localparam int PW    = 2 * WIDTH;
    localparam int LAST  = STAGES - 1;

    // Half an LSB of the result, added before the shift when rounding is enabled.
    localparam logic signed [PW-1:0] C_RND =
        (ROUND != 0) ? (PW'(1) << (FRACTIONAL - 1)) : '0;
    localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake and valid chain
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_valid;
    logic              w_advance;
    logic              w_accept;

    assign w_advance = io_bus.out_ready || !r_valid[LAST];
    assign w_accept  = io_bus.in_valid && w_advance;

    assign io_bus.in_ready  = w_advance;
    assign io_bus.out_valid = r_valid[LAST];
    assign io_bus.busy      = |r_valid;

    // Valid bits shift together whenever the pipe advances, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid <= {r_valid[STAGES-2:0], w_accept};
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: operand capture
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_b;

    // Capture operands only on a real transfer, so idle bus values never enter the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_accept) begin
            r_a <= io_bus.a;
            r_b <= io_bus.b;
        end
    end

    // Full-precision product. Both operands are sign-extended first, so the
    // low PW bits of the product are exact for every operand pair.
    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_prod;

    assign w_a_ext = PW'(r_a);
    assign w_b_ext = PW'(r_b);
    assign w_prod  = w_a_ext * w_b_ext;

    // ------------------------------------------------------------------
    // Stages 1..STAGES-2: product registers (stage 1 holds the product,
    // later ones are pure delay). Absent when STAGES == 2.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] w_final_p;

    for (genvar gi = 1; gi <= STAGES - 2; gi++) begin : g_mid
        logic signed [PW-1:0] r_p;
        logic signed [PW-1:0] w_src;

        if (gi == 1) begin : g_first
            assign w_src = w_prod;
        end else begin : g_chain
            assign w_src = g_mid[gi-1].r_p;
        end

        // Move the product one stage on when a valid entry arrives from the previous stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_p <= '0;
            end else if (w_advance && r_valid[gi-1]) begin
                r_p <= w_src;
            end
        end
    end

    if (STAGES > 2) begin : g_from_reg
        assign w_final_p = g_mid[STAGES-2].r_p;
    end else begin : g_from_mult
        assign w_final_p = w_prod;
    end

    // ------------------------------------------------------------------
    // Final stage: round, shift, range check
    // ------------------------------------------------------------------
    // The sum cannot overflow PW bits. The largest magnitude is
    // (-2^(W-1))^2 = 2^(2W-2), and C_RND is far smaller than the headroom left.
    logic signed [PW-1:0]    w_sum;
    logic signed [PW-1:0]    w_q;
    logic                    w_ovf;
    logic signed [WIDTH-1:0] w_sat;
    logic signed [WIDTH-1:0] w_res;

    assign w_sum = w_final_p + C_RND;
    assign w_q   = w_sum >>> FRACTIONAL;

    // q fits in WIDTH bits exactly when every bit from WIDTH-1 upward equals the sign bit.
    assign w_ovf = (w_q[PW-1:WIDTH-1] != {(PW-WIDTH+1){w_q[PW-1]}});
    assign w_sat = w_q[PW-1] ? C_MIN : C_MAX;
    assign w_res = (w_ovf && (SATURATE != 0)) ? w_sat : w_q[WIDTH-1:0];

    logic signed [WIDTH-1:0] r_result;
    logic                    r_overflow;

    // Output register. It holds during back-pressure and loads only valid entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (w_advance && r_valid[LAST-1]) begin
            r_result   <= w_res;
            r_overflow <= w_ovf;
        end
    end

    assign io_bus.result   = r_result;
    assign io_bus.overflow = r_overflow;

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Directed bench for fixed_mult_pipe at Q11.11, STAGES=3.
// Three instances share the same stimulus:
//   dut_def  ROUND=0 SATURATE=1
//   dut_rnd  ROUND=1 SATURATE=1
//   dut_wrp  ROUND=0 SATURATE=0
module tb_fixed_mult_pipe;
    localparam int W = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fixed_mult_pipe_if #(.WIDTH(W)) bus_def ();
    fixed_mult_pipe_if #(.WIDTH(W)) bus_rnd ();
    fixed_mult_pipe_if #(.WIDTH(W)) bus_wrp ();

    fixed_mult_pipe #(.INTEGRAL(11), .FRACTIONAL(11), .STAGES(3), .ROUND(0), .SATURATE(1))
        dut_def (.clk(clk), .rst(rst), .io_bus(bus_def));
    fixed_mult_pipe #(.INTEGRAL(11), .FRACTIONAL(11), .STAGES(3), .ROUND(1), .SATURATE(1))
        dut_rnd (.clk(clk), .rst(rst), .io_bus(bus_rnd));
    fixed_mult_pipe #(.INTEGRAL(11), .FRACTIONAL(11), .STAGES(3), .ROUND(0), .SATURATE(0))
        dut_wrp (.clk(clk), .rst(rst), .io_bus(bus_wrp));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic signed [W-1:0] r_def;
        logic                o_def;
        logic signed [W-1:0] r_rnd;
        logic                o_rnd;
        logic signed [W-1:0] r_wrp;
        logic                o_wrp;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input int a, input int b,
                                input int rd, input int od,
                                input int rr, input int orr,
                                input int rw, input int ow);
        vec_t v;
        v.a     = W'(a);
        v.b     = W'(b);
        v.r_def = W'(rd);
        v.o_def = 1'(od);
        v.r_rnd = W'(rr);
        v.o_rnd = 1'(orr);
        v.r_wrp = W'(rw);
        v.o_wrp = 1'(ow);
        return v;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic signed [W-1:0] av,
                         input logic signed [W-1:0] bv);
        bus_def.in_valid = v; bus_def.a = av; bus_def.b = bv;
        bus_rnd.in_valid = v; bus_rnd.a = av; bus_rnd.b = bv;
        bus_wrp.in_valid = v; bus_wrp.a = av; bus_wrp.b = bv;
    endtask

    task automatic set_ready(input logic r);
        bus_def.out_ready = r;
        bus_rnd.out_ready = r;
        bus_wrp.out_ready = r;
    endtask

    // Wait for out_valid on the default instance after an accepting edge.
    // The return value is the number of edges waited, or 99 on timeout.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus_def.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus_def.out_valid) lat = 99;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int sent;
        int got;
        int cyc;
        logic orv;
        logic acc;
        logic emit;
        logic stall_prev;
        logic signed [W-1:0] prev_res;

        // Hand-computed vectors (raw Q11.11 integers): a, b,
        // {trunc+sat}, {round+sat}, {trunc+wrap} result/overflow pairs.
        vecs[0]  = mk(-2048, -4096,     4096, 0,     4096, 0,     4096, 0);
        vecs[1]  = mk(1024, -1024,      -512, 0,     -512, 0,     -512, 0);
        vecs[2]  = mk(1, 1024,             0, 0,        1, 0,        0, 0);
        vecs[3]  = mk(-1, 1024,           -1, 0,        0, 0,       -1, 0);
        vecs[4]  = mk(81920, 81920,  2097151, 1,  2097151, 1,  -917504, 1);
        vecs[5]  = mk(81920, -81920, -2097152, 1, -2097152, 1,   917504, 1);
        vecs[6]  = mk(-2097152, -2097152, 2097151, 1, 2097151, 1,     0, 1);
        vecs[7]  = mk(0, -2097152,         0, 0,        0, 0,        0, 0);
        vecs[8]  = mk(91136, 47127,  2097151, 0,  2097151, 1,  2097151, 0);
        vecs[9]  = mk(3, -1,              -1, 0,        0, 0,       -1, 0);
        vecs[10] = mk(11264, 6144,     33792, 0,    33792, 0,    33792, 0);
        vecs[11] = mk(-3, 1024,           -2, 0,       -1, 0,       -2, 0);
        vecs[12] = mk(-2097152, 2048, -2097152, 0, -2097152, 0, -2097152, 0);

        drive(1'b0, '0, '0);
        set_ready(1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_out_valid", bus_def.out_valid, 0);
        check("reset_busy",      bus_def.busy,      0);
        check("reset_result",    bus_def.result,    0);
        check("reset_overflow",  bus_def.overflow,  0);
        check("reset_in_ready",  bus_def.in_ready,  1);

        // Table-driven single transactions.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            drive(1'b0, '0, '0);
            wait_out(lat);
            check($sformatf("v%0d_latency", i), lat, 2);
            check($sformatf("v%0d_def_result", i),   bus_def.result,   vecs[i].r_def);
            check($sformatf("v%0d_def_overflow", i), bus_def.overflow, vecs[i].o_def);
            check($sformatf("v%0d_rnd_result", i),   bus_rnd.result,   vecs[i].r_rnd);
            check($sformatf("v%0d_rnd_overflow", i), bus_rnd.overflow, vecs[i].o_rnd);
            check($sformatf("v%0d_wrp_result", i),   bus_wrp.result,   vecs[i].r_wrp);
            check($sformatf("v%0d_wrp_overflow", i), bus_wrp.overflow, vecs[i].o_wrp);
            $display("vec %0d a=%0d b=%0d def=%0d/%0d rnd=%0d/%0d wrp=%0d/%0d", i,
                     vecs[i].a, vecs[i].b, bus_def.result, bus_def.overflow,
                     bus_rnd.result, bus_rnd.overflow, bus_wrp.result, bus_wrp.overflow);
        end
        // Drain the last result.
        @(posedge clk); #1;
        check("drain_out_valid", bus_def.out_valid, 0);

        // Back-pressure: out_ready follows 1,0,0,1,0,0,...
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; prev_res = '0;
        while (got < 6 && cyc < 200) begin
            orv = (cyc % 3 == 0);
            set_ready(orv);
            if (sent < 6) drive(1'b1, W'((sent + 1) * 2048), W'(2048));
            else          drive(1'b0, '0, '0);
            #1;
            check($sformatf("bp_c%0d_in_ready", cyc), bus_def.in_ready,
                  longint'(orv || !bus_def.out_valid));
            if (stall_prev)
                check($sformatf("bp_c%0d_stable", cyc), bus_def.result, prev_res);
            acc  = bus_def.in_valid && bus_def.in_ready;
            emit = bus_def.out_valid && orv;
            stall_prev = bus_def.out_valid && !orv;
            prev_res   = bus_def.result;
            if (emit) begin
                check($sformatf("bp_result%0d", got), bus_def.result, (got + 1) * 2048);
                $display("bp emit %0d result=%0d", got, bus_def.result);
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        check("bp_count", got, 6);
        drive(1'b0, '0, '0);
        set_ready(1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_extra", bus_def.out_valid, 0);
        check("bp_idle_busy", bus_def.busy, 0);

        // Reset with three entries in flight.
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, W'(k * 2048), W'(2048));
            @(posedge clk); #1;
        end
        check("mid_busy_before", bus_def.busy, 1);
        check("mid_valid_before", bus_def.out_valid, 1);
        rst = 1'b1;
        drive(1'b1, W'(7 * 2048), W'(2048));
        @(posedge clk); #1;
        check("mid_out_valid", bus_def.out_valid, 0);
        check("mid_busy",      bus_def.busy,      0);
        check("mid_result",    bus_def.result,    0);
        $display("mid reset out_valid=%0d busy=%0d result=%0d",
                 bus_def.out_valid, bus_def.busy, bus_def.result);
        rst = 1'b0;
        drive(1'b1, W'(3 * 2048), W'(4096));
        @(posedge clk); #1;
        drive(1'b0, '0, '0);
        wait_out(lat);
        check("post_reset_latency", lat, 2);
        check("post_reset_result", bus_def.result, 12288);
        $display("post reset result=%0d latency=%0d", bus_def.result, lat);
        @(posedge clk); #1;
        check("post_reset_drain", bus_def.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
